// File: rtl/uart_rx_core.sv
// UART receive path: baud tick divider, 2-flop RX synchroniser, 16x-oversampling
// receiver FSM and an RX FIFO with per-entry error flags, overrun and char timeout.
module uart_rx_core #(
    parameter int DL_W       = 16,
    parameter int DEPTH      = 16,
    parameter int CNT_W      = $clog2(DEPTH) + 1,
    parameter int TOUT_TICKS = 640
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DL_W-1:0]  dl,
    input  logic             rx_en,
    input  logic [1:0]       cfg_wlen,
    input  logic             cfg_par_en,
    input  logic             cfg_par_even,
    input  logic             rf_pop,
    input  logic             rf_clr,
    input  logic             ovr_clr,
    input  logic             srx_pad_i,
    output logic [7:0]       rdr,
    output logic [2:0]       rf_err,
    output logic [CNT_W-1:0] rf_count,
    output logic             rf_empty,
    output logic             rf_full,
    output logic             rf_overrun,
    output logic             rx_timeout
);
    localparam int AW   = $clog2(DEPTH);
    localparam int TC_W = $clog2(TOUT_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK
    } state_t;

    // Baud divider: dl==0 parks the counter at 0 so a new dl is picked up at once.
    logic [DL_W-1:0] dlc;
    logic            tick;

    assign tick = (dlc == '0) && (dl != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dlc <= '0;
        else if (dlc == '0)
            dlc <= (dl == '0) ? '0 : dl - DL_W'(1);
        else
            dlc <= dlc - DL_W'(1);
    end

    logic [1:0] sync_q;
    logic       rxs;

    assign rxs = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sync_q <= 2'b11;
        else
            sync_q <= {sync_q[0], srx_pad_i};
    end

    state_t      state, state_n;
    logic [3:0]  sc, sc_n;
    logic [2:0]  bit_idx, bit_n;
    logic [7:0]  data, data_n;
    logic        par_bit, par_bit_n;
    logic        par_err, par_err_n;
    logic        push, frame_err, brk;
    logic [2:0]  last_bit;

    assign last_bit = {1'b0, cfg_wlen} + 3'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sc      <= '0;
            bit_idx <= '0;
            data    <= '0;
            par_bit <= 1'b0;
            par_err <= 1'b0;
        end else begin
            state   <= state_n;
            sc      <= sc_n;
            bit_idx <= bit_n;
            data    <= data_n;
            par_bit <= par_bit_n;
            par_err <= par_err_n;
        end
    end

    always_comb begin
        state_n   = state;
        sc_n      = sc;
        bit_n     = bit_idx;
        data_n    = data;
        par_bit_n = par_bit;
        par_err_n = par_err;
        push      = 1'b0;
        frame_err = 1'b0;
        brk       = 1'b0;
        if (!rx_en) begin
            state_n = S_IDLE;
            sc_n    = '0;
        end else if (tick) begin
            case (state)
                S_IDLE: begin
                    if (!rxs) begin
                        state_n = S_START;
                        sc_n    = '0;
                    end
                end
                S_START: begin
                    if (sc == 4'd7) begin
                        sc_n = '0;
                        if (rxs) begin
                            state_n = S_IDLE;
                        end else begin
                            state_n   = S_DATA;
                            bit_n     = '0;
                            data_n    = '0;
                            par_bit_n = 1'b0;
                            par_err_n = 1'b0;
                        end
                    end else begin
                        sc_n = sc + 4'd1;
                    end
                end
                S_DATA: begin
                    sc_n = sc + 4'd1;
                    if (sc == 4'd15) begin
                        data_n[bit_idx] = rxs;
                        bit_n           = bit_idx + 3'd1;
                        if (bit_idx == last_bit)
                            state_n = cfg_par_en ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    sc_n = sc + 4'd1;
                    if (sc == 4'd15) begin
                        par_bit_n = rxs;
                        // data bits above the word length are zero, so ^data is the data parity
                        par_err_n = (^data) ^ rxs ^ ~cfg_par_even;
                        state_n   = S_STOP;
                    end
                end
                S_STOP: begin
                    sc_n = sc + 4'd1;
                    if (sc == 4'd15) begin
                        frame_err = !rxs;
                        brk       = !rxs && (data == 8'd0) && !par_bit;
                        push      = 1'b1;
                        state_n   = brk ? S_BRK : S_IDLE;
                    end
                end
                S_BRK: begin
                    if (rxs) begin
                        state_n = S_IDLE;
                        sc_n    = '0;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    sc_n    = '0;
                end
            endcase
        end
    end

    logic [10:0]   mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [10:0]   head;
    logic          do_push, do_pop, ovf;

    assign rf_empty = (rf_count == '0);
    assign rf_full  = (rf_count == CNT_W'(DEPTH));
    assign do_pop   = rf_pop && !rf_empty && !rf_clr;
    assign do_push  = push && !rf_clr && (!rf_full || do_pop);
    assign ovf      = push && !rf_clr && rf_full && !do_pop;
    assign head     = mem[rd_ptr];
    assign rdr      = rf_empty ? 8'd0 : head[7:0];
    assign rf_err   = rf_empty ? 3'd0 : head[10:8];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= {brk, frame_err, par_err, data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rf_count <= '0;
        end else if (rf_clr) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rf_count <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   rf_count <= rf_count + CNT_W'(1);
                2'b01:   rf_count <= rf_count - CNT_W'(1);
                default: rf_count <= rf_count;
            endcase
        end
    end

    // A drop in the same cycle as ovr_clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rf_overrun <= 1'b0;
        else if (ovf)
            rf_overrun <= 1'b1;
        else if (ovr_clr)
            rf_overrun <= 1'b0;
    end

    logic [TC_W-1:0] tc;

    assign rx_timeout = (tc == TC_W'(TOUT_TICKS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tc <= '0;
        else if (push || rf_pop || rf_clr || rf_empty)
            tc <= '0;
        else if (tick && state == S_IDLE && !rx_timeout)
            tc <= tc + TC_W'(1);
    end
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: table of frames plus hand-written sequences
// for glitch, break, overflow, flush, timeout and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx_core;
    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [15:0] dl = 16'd4;
    logic       rx_en = 1'b1;
    logic [1:0] cfg_wlen = 2'd3;
    logic       cfg_par_en = 1'b0;
    logic       cfg_par_even = 1'b0;
    logic       rf_pop = 1'b0;
    logic       rf_clr = 1'b0;
    logic       ovr_clr = 1'b0;
    logic       srx_pad_i = 1'b1;
    logic [7:0] rdr;
    logic [2:0] rf_err;
    logic [2:0] rf_count;
    logic       rf_empty, rf_full, rf_overrun, rx_timeout;

    int checks = 0;
    int failures = 0;

    uart_rx_core #(.DL_W(16), .DEPTH(4), .CNT_W(3), .TOUT_TICKS(640)) dut (
        .clk(clk), .rst_n(rst_n), .dl(dl), .rx_en(rx_en),
        .cfg_wlen(cfg_wlen), .cfg_par_en(cfg_par_en), .cfg_par_even(cfg_par_even),
        .rf_pop(rf_pop), .rf_clr(rf_clr), .ovr_clr(ovr_clr), .srx_pad_i(srx_pad_i),
        .rdr(rdr), .rf_err(rf_err), .rf_count(rf_count), .rf_empty(rf_empty),
        .rf_full(rf_full), .rf_overrun(rf_overrun), .rx_timeout(rx_timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "time limit");
    end

    typedef struct {
        logic [7:0] data;
        int         nbits;
        logic [1:0] wlen;
        logic       par_en;
        logic       par_even;
        logic       par_bit;
        logic       stop;
        logic [7:0] exp_rdr;
        logic [2:0] exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                              input logic pbit, input logic stop);
        srx_pad_i = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < nbits; i++) begin
            srx_pad_i = d[i];
            wait_clk(BIT);
        end
        if (par_en) begin
            srx_pad_i = pbit;
            wait_clk(BIT);
        end
        if (!stop) begin
            srx_pad_i = 1'b0;
            wait_clk(BIT);
        end
        srx_pad_i = 1'b1;
    endtask

    task automatic pop;
        @(negedge clk) rf_pop = 1'b1;
        @(negedge clk) rf_pop = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdr"}, rdr, 8'h00);
        check({tag, "_err"}, rf_err, 3'b000);
        check({tag, "_count"}, rf_count, 3'd0);
        check({tag, "_empty"}, rf_empty, 1'b1);
        check({tag, "_full"}, rf_full, 1'b0);
        check({tag, "_ovr"}, rf_overrun, 1'b0);
        check({tag, "_tout"}, rx_timeout, 1'b0);
    endtask

    initial begin
        int n;
        vecs[0]  = '{8'hA5, 8, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 3'b000};
        vecs[1]  = '{8'h41, 7, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'h41, 3'b001};
        vecs[2]  = '{8'h41, 7, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 8'h41, 3'b000};
        vecs[3]  = '{8'h15, 5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h15, 3'b000};
        vecs[4]  = '{8'h2A, 6, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h2A, 3'b000};
        vecs[5]  = '{8'h2A, 6, 2'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h2A, 3'b001};
        vecs[6]  = '{8'hFF, 8, 2'd3, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 3'b000};
        vecs[7]  = '{8'h81, 8, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 3'b010};
        vecs[8]  = '{8'hFF, 6, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3F, 3'b000};
        vecs[9]  = '{8'h00, 8, 2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 3'b011};
        vecs[10] = '{8'h00, 5, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'b110};

        // reset
        wait_clk(5);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_clk(5);
        check_reset_outputs("post_reset");

        // 0xA5, push must land inside the stop bit
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        wait_clk(16);
        check("a5_count_early_stop", rf_count, 3'd0);
        wait_clk(48);
        check("a5_count_end_stop", rf_count, 3'd1);
        check("a5_rdr", rdr, 8'hA5);
        check("a5_err", rf_err, 3'b000);
        pop();
        check("a5_empty_after_pop", rf_empty, 1'b1);

        // table of frames
        for (int v = 0; v < 11; v++) begin
            cfg_wlen     = vecs[v].wlen;
            cfg_par_en   = vecs[v].par_en;
            cfg_par_even = vecs[v].par_even;
            wait_clk(10);
            send_frame(vecs[v].data, vecs[v].nbits, vecs[v].par_en, vecs[v].par_bit, vecs[v].stop);
            wait_clk(80);
            check($sformatf("vec%0d_count", v), rf_count, 3'd1);
            check($sformatf("vec%0d_rdr", v), rdr, vecs[v].exp_rdr);
            check($sformatf("vec%0d_err", v), rf_err, vecs[v].exp_err);
            pop();
            check($sformatf("vec%0d_empty", v), rf_empty, 1'b1);
        end
        cfg_wlen = 2'd3; cfg_par_en = 1'b0; cfg_par_even = 1'b0;

        // short low glitch is a false start
        wait_clk(20);
        srx_pad_i = 1'b0;
        wait_clk(16);
        srx_pad_i = 1'b1;
        wait_clk(200);
        check("glitch_count", rf_count, 3'd0);
        send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
        wait_clk(80);
        check("after_glitch_rdr", rdr, 8'hC3);
        pop();

        // dl=0 stops the receiver
        dl = 16'd0;
        srx_pad_i = 1'b0;
        wait_clk(300);
        srx_pad_i = 1'b1;
        wait_clk(20);
        dl = 16'd4;
        wait_clk(100);
        check("dl0_count", rf_count, 3'd0);

        // long break gives exactly one entry
        srx_pad_i = 1'b0;
        wait_clk(3 * 10 * BIT);
        srx_pad_i = 1'b1;
        wait_clk(100);
        check("brk_count", rf_count, 3'd1);
        check("brk_rdr", rdr, 8'h00);
        check("brk_err", rf_err, 3'b110);
        pop();
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        wait_clk(80);
        check("post_brk_count", rf_count, 3'd1);
        check("post_brk_rdr", rdr, 8'h3C);
        check("post_brk_err", rf_err, 3'b000);
        pop();

        // overflow
        for (int b = 1; b <= 5; b++) begin
            send_frame(8'(b), 8, 1'b0, 1'b0, 1'b1);
            wait_clk(80);
        end
        check("ovf_count", rf_count, 3'd4);
        check("ovf_full", rf_full, 1'b1);
        check("ovf_overrun", rf_overrun, 1'b1);
        check("ovf_head", rdr, 8'h01);
        for (int b = 1; b <= 4; b++) begin
            check($sformatf("ovf_pop%0d_rdr", b), rdr, 32'(b));
            pop();
        end
        check("ovf_drained_empty", rf_empty, 1'b1);
        pop();
        check("pop_empty_count", rf_count, 3'd0);
        check("pop_empty_rdr", rdr, 8'h00);

        // flush keeps overrun; ovr_clr clears it
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
        wait_clk(80);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
        wait_clk(80);
        check("clr_pre_count", rf_count, 3'd2);
        @(negedge clk) rf_clr = 1'b1;
        @(negedge clk) rf_clr = 1'b0;
        check("clr_count", rf_count, 3'd0);
        check("clr_overrun_kept", rf_overrun, 1'b1);
        @(negedge clk) ovr_clr = 1'b1;
        @(negedge clk) ovr_clr = 1'b0;
        check("ovr_clr", rf_overrun, 1'b0);

        // character timeout: 640 ticks of 4 clk after the push
        send_frame(8'h77, 8, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (rf_count != 3'd1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tout_push_seen", 32'(n < 200), 32'd1);
        wait_clk(640 * 4 - 1);
        check("tout_not_yet", rx_timeout, 1'b0);
        wait_clk(1);
        check("tout_asserted", rx_timeout, 1'b1);
        check("tout_rdr", rdr, 8'h77);
        pop();
        check("tout_cleared_by_pop", rx_timeout, 1'b0);

        // reset in the middle of a data bit
        send_frame(8'h99, 8, 1'b0, 1'b0, 1'b1);
        wait_clk(80);
        srx_pad_i = 1'b0;
        wait_clk(BIT);
        srx_pad_i = 1'b1;
        wait_clk(BIT);
        srx_pad_i = 1'b0;
        wait_clk(BIT / 2);
        rst_n = 1'b0;
        wait_clk(2);
        check_reset_outputs("midreset");
        srx_pad_i = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(100);
        check("midreset_idle_count", rf_count, 3'd0);
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1);
        wait_clk(80);
        check("midreset_next_count", rf_count, 3'd1);
        check("midreset_next_rdr", rdr, 8'h5A);
        check("midreset_next_err", rf_err, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
